// File: rtl/ysyx_25060170_ifu_fetch_pkg.sv
// ysyx_25060170_ifu_fetch_pkg: widths, reset PC, instruction step and FSM encoding shared by the fetch unit
package ysyx_25060170_ifu_fetch_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam int          ILEN_DEF     = 32;
   localparam logic [31:0] START_PC_DEF = 32'h8000_0000;
   localparam int          INST_STEP    = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

endpackage

// File: rtl/ysyx_25060170_ifu_pcgen.sv
// ysyx_25060170_ifu_pcgen: program counter with +4 advance and redirect load (redirect wins);
// without YSYX_25060170_IFU_MISALIGN_CHECK_EN the low two redirect bits are forced to zero
module ysyx_25060170_ifu_pcgen
   import ysyx_25060170_ifu_fetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] START_PC = START_PC_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            advance,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] load_pc;

`ifdef YSYX_25060170_IFU_MISALIGN_CHECK_EN
   assign load_pc = redirect_pc;
`else
   assign load_pc = redirect_pc & ~XLEN'(3);
`endif

   // PC register: redirect target has priority over sequential advance, which wraps silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= START_PC;
      else if (redirect_valid) pc <= load_pc;
      else if (advance) pc <= pc + XLEN'(INST_STEP);
   end

endmodule

// File: rtl/ysyx_25060170_ifu_fetch.sv
// ysyx_25060170_ifu_fetch: single-outstanding instruction fetch FSM feeding IF/ID over valid/ready;
// optional YSYX_25060170_IFU_MISALIGN_CHECK_EN adds if_misalign for misaligned redirect targets
module ysyx_25060170_ifu_fetch
   import ysyx_25060170_ifu_fetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter int              ILEN     = ILEN_DEF,
   parameter logic [XLEN-1:0] START_PC = START_PC_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   output logic [ILEN-1:0] if_inst,
   output logic [XLEN-1:0] if_pc,
`ifdef YSYX_25060170_IFU_MISALIGN_CHECK_EN
   output logic            if_misalign,
`endif
   input  logic            id_ready
);

   state_t          state;
   logic            drop;
   logic            advance;
   logic            launch;
   logic            tgt_mis;
   logic            hold_mis;
   logic [XLEN-1:0] pc;

   ysyx_25060170_ifu_pcgen #(
      .XLEN     (XLEN),
      .START_PC (START_PC)
   ) u_pcgen (
      .clk            (clk),
      .rst_n          (rst_n),
      .advance        (advance),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc             (pc)
   );

   assign imem_req_addr = pc;
   assign advance       = (state == S_WAIT) & imem_rsp_valid & ~drop & ~redirect_valid;

   // tgt_mis: the PC the unit is about to fetch from cannot be fetched and must be reported instead
`ifdef YSYX_25060170_IFU_MISALIGN_CHECK_EN
   assign tgt_mis  = redirect_valid ? |redirect_pc[1:0] : |pc[1:0];
   assign hold_mis = if_misalign;
`else
   assign tgt_mis  = 1'b0;
   assign hold_mis = 1'b0;
`endif

   // launch: (re)start fetching at the new PC, from idle, after a redirect, or once a stale response drains
   assign launch = (state == S_IDLE) ? (redirect_valid | ~tgt_mis) :
                   (state == S_REQ)  ? (redirect_valid & ~imem_req_ready) :
                   (state == S_WAIT) ? (imem_rsp_valid & (drop | redirect_valid)) :
                                       redirect_valid;

   // Fetch FSM with registered request and IF/ID outputs; a request accepted alongside a redirect is dropped later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         drop           <= 1'b0;
         if_valid       <= 1'b0;
         if_inst        <= '0;
         if_pc          <= '0;
         imem_req_valid <= 1'b0;
`ifdef YSYX_25060170_IFU_MISALIGN_CHECK_EN
         if_misalign    <= 1'b0;
`endif
      end else if (launch) begin
         state          <= tgt_mis ? S_HOLD : S_REQ;
         imem_req_valid <= ~tgt_mis;
         if_valid       <= tgt_mis;
         drop           <= 1'b0;
`ifdef YSYX_25060170_IFU_MISALIGN_CHECK_EN
         if_misalign    <= tgt_mis;
         if (tgt_mis) begin
            if_inst <= '0;
            if_pc   <= redirect_valid ? redirect_pc : pc;
         end
`endif
      end else begin
         case (state)
            S_REQ: begin
               if (imem_req_ready) begin
                  state          <= S_WAIT;
                  imem_req_valid <= 1'b0;
                  drop           <= redirect_valid;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  drop <= 1'b1;
               end else if (imem_rsp_valid) begin
                  if_inst  <= imem_rsp_data;
                  if_pc    <= pc;
                  if_valid <= 1'b1;
                  state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (id_ready) begin
                  if_valid       <= 1'b0;
                  state          <= hold_mis ? S_IDLE : S_REQ;
                  imem_req_valid <= ~hold_mis;
`ifdef YSYX_25060170_IFU_MISALIGN_CHECK_EN
                  if_misalign    <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25060170_ifu_fetch.sv
// tb_ysyx_25060170_ifu_fetch: randomized memory/redirect/stall stimulus checked against a stream-level fetch model
module tb_ysyx_25060170_ifu_fetch;

   localparam logic [31:0] START = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        id_ready = 1'b0;
`ifdef YSYX_25060170_IFU_MISALIGN_CHECK_EN
   logic        if_misalign;
`endif

   ysyx_25060170_ifu_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
`ifdef YSYX_25060170_IFU_MISALIGN_CHECK_EN
      .if_misalign    (if_misalign),
`endif
      .id_ready       (id_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // memory model: random ready, response after lat_lo..lat_hi cycles, data derived from the address
   typedef struct {
      int          due;
      logic [31:0] d;
   } rsp_t;
   rsp_t        pend[$];
   int          rdy_pct = 100;
   int          lat_lo = 1;
   int          lat_hi = 1;
   bit          force_en = 1'b0;
   logic [31:0] force_data = 32'hDEAD_BEEF;

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic drv(input bit rv, input logic [31:0] rpc, input bit idr);
      cyc++;
      redirect_valid = rv;
      redirect_pc    = rpc;
      id_ready       = idr;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = pend[0].d;
         void'(pend.pop_front());
      end
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      if (imem_req_valid && imem_req_ready)
         pend.push_back('{cyc + int'($urandom_range(lat_hi, lat_lo)), force_en ? force_data : memfn(imem_req_addr)});
   endtask

   // stream model: expected next PC to deliver, outstanding count, previous-cycle handshake snapshot
   logic [31:0] exp_pc = START;
   int          outst = 0;
   bit          p_stall = 1'b0;
   bit          p_kick = 1'b0;
   logic [31:0] p_pc, p_inst;
   logic        ck_xfer;
   int          n_xfer = 0;
   logic [31:0] xq_pc[$];
   int          xq_cyc[$];
   bit          saw_bad = 1'b0;

   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         exp_pc  = START;
         outst   = 0;
         p_stall = 1'b0;
         p_kick  = 1'b0;
      end else begin
         ck_xfer = if_valid && id_ready && !redirect_valid;
         if (outst > 0) chk("req_while_outstanding", 32'(imem_req_valid), 32'd0);
         if (imem_req_valid && !redirect_valid) chk("req_addr", imem_req_addr, exp_pc);
         if (if_valid) chk("req_during_hold", 32'(imem_req_valid), 32'd0);
         if (p_stall) begin
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_pc", if_pc, p_pc);
            chk("hold_inst", if_inst, p_inst);
         end
         if (p_kick) begin
            chk("req_after_hold", 32'(imem_req_valid), 32'd1);
            chk("valid_after_hold", 32'(if_valid), 32'd0);
         end
         if (ck_xfer) begin
            chk("xfer_pc", if_pc, exp_pc);
            chk("xfer_inst", if_inst, memfn(if_pc));
            n_xfer++;
            xq_pc.push_back(if_pc);
            xq_cyc.push_back(cyc);
         end
         if (if_valid && if_inst == 32'hDEAD_BEEF) saw_bad = 1'b1;
         if (imem_req_valid && imem_req_ready) outst++;
         if (imem_rsp_valid && outst > 0) outst--;
         p_stall = if_valid && !id_ready && !redirect_valid;
         p_kick  = if_valid && (id_ready || redirect_valid);
         p_pc    = if_pc;
         p_inst  = if_inst;
         exp_pc  = redirect_valid ? (redirect_pc & ~32'h3) : ck_xfer ? exp_pc + 32'd4 : exp_pc;
      end
   end

   task automatic do_reset();
      nxt();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      id_ready       = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      pend.delete();
      rdy_pct  = 100;
      lat_lo   = 1;
      lat_hi   = 1;
      force_en = 1'b0;
      repeat (2) nxt();
      chk("reset_if_valid", 32'(if_valid), 32'd0);
      chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
      chk("reset_if_pc", if_pc, 32'd0);
      chk("reset_if_inst", if_inst, 32'd0);
      rst_n = 1'b1;
      chk("idle_no_req", 32'(imem_req_valid), 32'd0);
      xq_pc.delete();
      xq_cyc.delete();
   endtask

   task automatic wait_req(output logic [31:0] a, output bit got);
      got = 1'b0;
      a   = '0;
      for (int k = 0; k < 20; k++) begin
         nxt();
         got = imem_req_valid;
         a   = imem_req_addr;
         drv(1'b0, '0, 1'b1);
         if (got) break;
      end
   endtask

   task automatic wait_xfer(output logic [31:0] p, output bit got);
      got = 1'b0;
      p   = '0;
      for (int k = 0; k < 20; k++) begin
         nxt();
         got = if_valid;
         p   = if_pc;
         drv(1'b0, '0, 1'b1);
         if (got) break;
      end
   endtask

   task automatic wait_valid(output bit got);
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         nxt();
         got = if_valid;
         drv(1'b0, '0, 1'b0);
         if (got) break;
      end
   endtask

   initial begin
      logic [31:0] a, p, hp, hi, rpc;
      bit          got, hit;
      int          n0;

      // 1: 1-cycle memory, id_ready held high: START, +4, +8 delivered three cycles apart
      do_reset();
      nxt();
      chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t1_first_req_addr", imem_req_addr, START);
      drv(1'b0, '0, 1'b1);
      repeat (12) begin
         nxt();
         drv(1'b0, '0, 1'b1);
      end
      #3;
      chk("t1_xfer_count", xq_pc.size(), 32'd4);
      if (xq_pc.size() >= 3) begin
         chk("t1_pc0", xq_pc[0], 32'h8000_0000);
         chk("t1_pc1", xq_pc[1], 32'h8000_0004);
         chk("t1_pc2", xq_pc[2], 32'h8000_0008);
         chk("t1_gap01", xq_cyc[1] - xq_cyc[0], 32'd3);
         chk("t1_gap12", xq_cyc[2] - xq_cyc[1], 32'd3);
      end

      // 2: five stalled cycles in HOLD, then exactly one transfer
      do_reset();
      wait_valid(got);
      chk("t2_reached_hold", 32'(got), 32'd1);
      hp = if_pc;
      hi = if_inst;
      chk("t2_pc", hp, START);
      chk("t2_inst", hi, memfn(START));
      n0 = n_xfer;
      repeat (5) begin
         nxt();
         chk("t2_stall_valid", 32'(if_valid), 32'd1);
         chk("t2_stall_pc", if_pc, hp);
         chk("t2_stall_inst", if_inst, hi);
         chk("t2_stall_no_req", 32'(imem_req_valid), 32'd0);
         drv(1'b0, '0, 1'b0);
      end
      nxt();
      drv(1'b0, '0, 1'b1);
      nxt();
      drv(1'b0, '0, 1'b0);
      #3;
      chk("t2_one_xfer", n_xfer - n0, 32'd1);

      // 3: redirect while waiting on a slow response carrying 0xDEADBEEF
      do_reset();
      lat_lo   = 4;
      lat_hi   = 4;
      force_en = 1'b1;
      saw_bad  = 1'b0;
      got      = 1'b0;
      for (int k = 0; k < 20; k++) begin
         nxt();
         drv(1'b0, '0, 1'b1);
         got = imem_req_valid && imem_req_ready;
         if (got) break;
      end
      force_en = 1'b0;
      lat_lo   = 1;
      lat_hi   = 1;
      chk("t3_accepted", 32'(got), 32'd1);
      nxt();
      drv(1'b1, 32'h8000_0100, 1'b1);
      wait_req(a, got);
      chk("t3_req_seen", 32'(got), 32'd1);
      chk("t3_req_addr", a, 32'h8000_0100);
      wait_xfer(p, got);
      chk("t3_xfer_seen", 32'(got), 32'd1);
      chk("t3_xfer_pc", p, 32'h8000_0100);
      #3;
      chk("t3_no_stale_data", 32'(saw_bad), 32'd0);

      // 4: redirect in HOLD with id_ready high is not a transfer
      do_reset();
      wait_valid(got);
      chk("t4_reached_hold", 32'(got), 32'd1);
      n0 = n_xfer;
      nxt();
      chk("t4_still_hold", 32'(if_valid), 32'd1);
      drv(1'b1, 32'h8000_0200, 1'b1);
      nxt();
      chk("t4_valid_cleared", 32'(if_valid), 32'd0);
      chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t4_req_addr", imem_req_addr, 32'h8000_0200);
      drv(1'b0, '0, 1'b1);
      #3;
      chk("t4_no_xfer", n_xfer - n0, 32'd0);

      // 5: redirect in the same cycle the request for 0x8000_0010 is accepted
      do_reset();
      hit = 1'b0;
      for (int k = 0; k < 40; k++) begin
         nxt();
         hit = imem_req_valid && imem_req_addr == 32'h8000_0010;
         if (hit) drv(1'b1, 32'h8000_0300, 1'b1);
         else drv(1'b0, '0, 1'b1);
         if (hit) break;
      end
      chk("t5_hit", 32'(hit), 32'd1);
      chk("t5_accept_same_cycle", 32'(imem_req_ready), 32'd1);
      wait_req(a, got);
      chk("t5_req_seen", 32'(got), 32'd1);
      chk("t5_req_addr", a, 32'h8000_0300);
      wait_xfer(p, got);
      chk("t5_xfer_pc", p, 32'h8000_0300);

      // 6: PC wrap after 0xFFFF_FFFC, and low redirect bits are ignored
      do_reset();
      rdy_pct = 0;
      nxt();
      drv(1'b1, 32'hFFFF_FFFC, 1'b1);
      rdy_pct = 100;
      wait_req(a, got);
      chk("t6_req_top", a, 32'hFFFF_FFFC);
      wait_xfer(p, got);
      chk("t6_xfer_top", p, 32'hFFFF_FFFC);
      wait_req(a, got);
      chk("t6_req_wrap", a, 32'h0000_0000);
      nxt();
      drv(1'b1, 32'h8000_0402, 1'b1);
      wait_req(a, got);
      chk("t6_req_aligned", a, 32'h8000_0400);

      // random phase: random ready/latency/stalls/redirects, checked each cycle by the model
      do_reset();
      n0 = n_xfer;
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) begin
            rdy_pct = int'($urandom_range(100, 20));
            lat_hi  = int'($urandom_range(5, 1));
         end
         rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         nxt();
         drv($urandom_range(99) < 6, rpc, $urandom_range(99) < 70);
      end
      #3;
      chk("rand_progress", 32'(n_xfer - n0 > 100), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
